led_scroller: RTL
=================

// Module: led_scroller
//
// PURPOSE
//   Upstream feeder for the 4x8 LED matrix driver. Accepts 8-bit column bytes
//   on a valid/ready stream and buffers them in a small FIFO. Maintains the
//   32-bit display word and scrolls it left by one column every
//   FRAMES_PER_STEP frames, paced by the driver's frame_tick.
//   data[31:24] is the leftmost column and data[7:0] is the rightmost column.
//
// PARAMETERS
//   FRAMES_PER_STEP  8  frames per scroll step; legal range 1..255
//   FIFO_DEPTH       8  column FIFO entries; power of 2, >= 2
//
// PORTS
//   clk         in   1   system clock (12 MHz)
//   rst_n       in   1   asynchronous reset, active low
//   in_data     in   8   column byte, bit 7 = top row, '1' = LED on
//   in_valid    in   1   in_data is valid
//   in_ready    out  1   FIFO can accept; equals !full
//   frame_tick  in   1   one-cycle pulse per frame, from the matrix driver
//   enable      in   1   1 = scrolling runs; 0 = frame count and data freeze
//   clear       in   1   synchronous flush of FIFO, data and frame count
//   data        out  32  display word, to the matrix driver's data input
//   step_tick   out  1   one-cycle pulse in the cycle data changes
//   underrun    out  1   one-cycle pulse: a step occurred with the FIFO empty
//   fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): data=0, FIFO empty, fifo_level=0, in_ready=1,
//     frame counter=0, step_tick=0, underrun=0.
//   - Push: a push occurs on a rising edge where in_valid & in_ready.
//     in_ready is combinational !full. There is no push-when-full bypass.
//   - Frame counter: advances only on a cycle where frame_tick & enable.
//   - Step: occurs on a frame_tick & enable cycle where the counter equals
//     FRAMES_PER_STEP-1. The counter returns to 0.
//     On the same edge, data <= {data[23:0], col}.
//     col is the FIFO head, which is popped, if the FIFO is non-empty.
//     Otherwise col=8'h00 and underrun is pulsed.
//   - Latency: data, step_tick and underrun update on the edge that samples
//     the qualifying frame_tick, so they are visible in the following cycle.
//     Each pulse lasts exactly one cycle.
//   - FIFO status: empty/full are evaluated from pre-edge state.
//   - Push and step in the same cycle on a non-empty FIFO: both succeed and
//     the level is unchanged.
//   - Push and step in the same cycle on an empty FIFO: the step shifts in
//     8'h00 and pulses underrun. The pushed byte stays queued (level 1).
//   - Push and step in the same cycle on a full FIFO: in_ready=0, so the pop
//     happens without a push. The freed slot shows in_ready=1 next cycle.
//   - enable=0: the frame counter holds, no steps occur, and data holds.
//     Pushes are still accepted.
//   - clear=1: on the next edge the FIFO empties, data=0 and the counter=0.
//     clear has priority over push and step; no step_tick/underrun that cycle.
//   - Reset asserted mid-step: the asynchronous reset wins. All state returns
//     to reset values immediately and no partial shift is retained.
//   - Pointers: (log2 DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH.
//     full when the pointer MSBs differ and the low bits are equal.
//
// TESTING
//   1. Reset, FRAMES_PER_STEP=2: push 8'hAA,8'h55; send 4 frame_ticks
//      -> step after frames 2 and 4; data=32'h0000_00AA then 32'h0000_AA55.
//   2. Empty FIFO, enable=1: send 2 frame_ticks -> data stays 0; underrun
//      pulses once with step_tick; fifo_level=0.
//   3. Fill: hold in_valid for 10 cycles, FIFO_DEPTH=8 -> exactly 8 accepted;
//      in_ready=0 from the cycle after the 8th push; fifo_level=8.
//   4. Full FIFO with in_valid held, trigger a step -> 1 pop; in_ready=1
//      next cycle; the 9th byte is accepted; fifo_level returns to 8.
//   5. Push on the same cycle as a step with the FIFO empty -> shifts 8'h00
//      with underrun=1; fifo_level=1 afterwards; the next step shifts that byte.
//   6. enable=0 across 5 frame_ticks, then clear=1 with 3 queued bytes ->
//      data unchanged while disabled; after clear, data=0, fifo_level=0,
//      no step_tick.

Source files
------------

// File: rtl/led_scroller.sv
// Column feeder for the 4x8 LED matrix driver: buffers column bytes in a FIFO
// and scrolls the 32-bit display word left one column every FRAMES_PER_STEP frames.
module led_scroller #(
   parameter  int FRAMES_PER_STEP = 8,
   parameter  int FIFO_DEPTH      = 8,
   localparam int AW              = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          frame_tick,
   input  logic          enable,
   input  logic          clear,
   output logic [31:0]   data,
   output logic          step_tick,
   output logic          underrun,
   output logic [AW:0]   fifo_level
);

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [7:0]  r_cnt;
   logic [31:0] r_data;
   logic        r_step;
   logic        r_under;

   logic        w_empty;
   logic        w_full;
   logic        w_push;
   logic        w_frame;
   logic        w_fire;
   logic        w_pop;
   logic [7:0]  w_col;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = in_valid && !w_full;
   assign w_frame = frame_tick && enable;
   assign w_fire  = w_frame && (r_cnt == LAST_FRAME);
   assign w_pop   = w_fire && !w_empty;
   assign w_col   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_step   <= 1'b0;
         r_under  <= 1'b0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_step   <= 1'b0;
         r_under  <= 1'b0;
      end else begin
         r_step  <= w_fire;
         r_under <= w_fire && w_empty;
         if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_frame) r_cnt    <= w_fire ? 8'd0 : r_cnt + 8'd1;
         if (w_fire)  r_data   <= {r_data[23:0], w_col};
      end
   end

   assign in_ready   = !w_full;
   assign data       = r_data;
   assign step_tick  = r_step;
   assign underrun   = r_under;
   assign fifo_level = r_wr_ptr - r_rd_ptr;

endmodule
